// File: rtl/count_checker.sv
// Monitors an external counter: locks onto a +1 (mod 2^WIDTH) sequence and
// reports violations while locked, keeping sticky/first-bad/saturating stats.
module count_checker #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned LOCK_LEN = 4,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] count_in,
  input  logic             clear,
  output logic             locked,
  output logic             error,
  output logic             sticky_err,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] exp_count,
  output logic [WIDTH-1:0] first_bad
);

  localparam int unsigned RUN_W = 4;

  typedef enum logic [1:0] {IDLE, SYNC, LOCK} state_t;

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic [RUN_W-1:0] run;

  logic [WIDTH-1:0] exp_c;
  logic             match_c;
  logic [RUN_W-1:0] run_inc_c;
  logic [ERR_W-1:0] err_base_c;
  logic [ERR_W-1:0] err_next_c;

  assign exp_c     = prev + WIDTH'(1);
  assign match_c   = (count_in == exp_c);
  assign run_inc_c = run + RUN_W'(1);

  // A violation on the same cycle as clear counts on top of the cleared value.
  assign err_base_c = clear ? '0 : err_count;
  assign err_next_c = (err_base_c == {ERR_W{1'b1}}) ? err_base_c : err_base_c + ERR_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      prev       <= '0;
      run        <= '0;
      locked     <= 1'b0;
      error      <= 1'b0;
      sticky_err <= 1'b0;
      err_count  <= '0;
      exp_count  <= '0;
      first_bad  <= '0;
    end else begin
      error <= 1'b0;
      if (clear) begin
        err_count  <= '0;
        sticky_err <= 1'b0;
        first_bad  <= '0;
      end
      if (en) begin
        prev      <= count_in;
        exp_count <= count_in + WIDTH'(1);
        unique case (state)
          IDLE: begin
            run   <= '0;
            state <= SYNC;
          end
          SYNC: begin
            if (match_c) begin
              run <= run_inc_c;
              if (run_inc_c == RUN_W'(LOCK_LEN)) begin
                state  <= LOCK;
                locked <= 1'b1;
              end
            end else begin
              run <= '0;
            end
          end
          LOCK: begin
            if (!match_c) begin
              error      <= 1'b1;
              sticky_err <= 1'b1;
              err_count  <= err_next_c;
              if (!sticky_err || clear) first_bad <= count_in;
              run    <= '0;
              state  <= SYNC;
              locked <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_count_checker.sv
// Directed bench for count_checker: default instance plus an ERR_W=2,
// LOCK_LEN=1 instance for saturation and single-step lock.
module tb_count_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, clear;
  logic [3:0] count_in;
  logic       locked, error, sticky_err;
  logic [7:0] err_count;
  logic [3:0] exp_count, first_bad;

  logic       en2, clear2;
  logic [3:0] count_in2;
  logic       locked2, error2, sticky_err2;
  logic [1:0] err_count2;
  logic [3:0] exp_count2, first_bad2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  count_checker u_dut (
    .clk(clk), .rst(rst), .en(en), .count_in(count_in), .clear(clear),
    .locked(locked), .error(error), .sticky_err(sticky_err),
    .err_count(err_count), .exp_count(exp_count), .first_bad(first_bad)
  );

  count_checker #(.WIDTH(4), .LOCK_LEN(1), .ERR_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .en(en2), .count_in(count_in2), .clear(clear2),
    .locked(locked2), .error(error2), .sticky_err(sticky_err2),
    .err_count(err_count2), .exp_count(exp_count2), .first_bad(first_bad2)
  );

  task automatic drive(input logic e, input logic [3:0] c, input logic cl);
    en = e; count_in = c; clear = cl;
    @(posedge clk); #1;
  endtask

  task automatic drive2(input logic e, input logic [3:0] c, input logic cl);
    en2 = e; count_in2 = c; clear2 = cl;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; en = 0; clear = 0; count_in = '0;
    en2 = 0; clear2 = 0; count_in2 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%b exp=0", locked); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got=%b exp=0", error); end
    checks++; if (sticky_err !== 1'b0) begin errors++; $display("FAIL reset_sticky got=%b exp=0", sticky_err); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
    checks++; if (exp_count !== 4'd0) begin errors++; $display("FAIL reset_exp_count got=%0d exp=0", exp_count); end
    checks++; if (first_bad !== 4'd0) begin errors++; $display("FAIL reset_first_bad got=%0d exp=0", first_bad); end
    rst = 1'b1;
  endtask

  task automatic test_lock;
    for (int i = 0; i <= 4; i++) begin
      drive(1'b1, 4'(i), 1'b0);
      checks++; if (locked !== (i == 4)) begin errors++; $display("FAIL lock_seq[%0d] got=%b exp=%b", i, locked, (i == 4)); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL lock_noerr[%0d] got=%b exp=0", i, error); end
    end
    checks++; if (exp_count !== 4'd5) begin errors++; $display("FAIL lock_exp got=%0d exp=5", exp_count); end
  endtask

  task automatic test_wrap;
    for (int i = 5; i <= 17; i++) begin
      drive(1'b1, 4'(i), 1'b0);
      checks++; if (error !== 1'b0 || locked !== 1'b1) begin errors++; $display("FAIL wrap[%0d] got err=%b lock=%b exp err=0 lock=1", i, error, locked); end
    end
    checks++; if (exp_count !== 4'd2) begin errors++; $display("FAIL wrap_exp got=%0d exp=2", exp_count); end
  endtask

  task automatic test_error;
    for (int i = 2; i <= 6; i++) drive(1'b1, 4'(i), 1'b0);
    drive(1'b1, 4'd9, 1'b0);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL err_pulse got=%b exp=1", error); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL err_count1 got=%0d exp=1", err_count); end
    checks++; if (sticky_err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", sticky_err); end
    checks++; if (first_bad !== 4'd9) begin errors++; $display("FAIL err_first_bad got=%0d exp=9", first_bad); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL err_unlock got=%b exp=0", locked); end
    checks++; if (exp_count !== 4'd10) begin errors++; $display("FAIL err_exp got=%0d exp=10", exp_count); end
    for (int i = 10; i <= 13; i++) begin
      drive(1'b1, 4'(i), 1'b0);
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL relock_noerr[%0d] got=%b exp=0", i, error); end
      checks++; if (locked !== (i == 13)) begin errors++; $display("FAIL relock[%0d] got=%b exp=%b", i, locked, (i == 13)); end
    end
  endtask

  task automatic test_stall_clear;
    drive(1'b0, 4'd0, 1'b1);
    checks++; if (err_count !== 8'd0 || sticky_err !== 1'b0 || first_bad !== 4'd0) begin errors++; $display("FAIL clear1 got cnt=%0d st=%b fb=%0d exp 0/0/0", err_count, sticky_err, first_bad); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL clear1_locked got=%b exp=1", locked); end
    for (int i = 14; i <= 23; i++) drive(1'b1, 4'(i), 1'b0);
    drive(1'b1, 4'd7, 1'b0);
    checks++; if (error !== 1'b1 || err_count !== 8'd1 || first_bad !== 4'd7) begin errors++; $display("FAIL stall got err=%b cnt=%0d fb=%0d exp 1/1/7", error, err_count, first_bad); end
    for (int i = 8; i <= 11; i++) drive(1'b1, 4'(i), 1'b0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL stall_relock got=%b exp=1", locked); end
    drive(1'b1, 4'd3, 1'b0);
    checks++; if (error !== 1'b1 || err_count !== 8'd2 || first_bad !== 4'd7) begin errors++; $display("FAIL second_err got err=%b cnt=%0d fb=%0d exp 1/2/7", error, err_count, first_bad); end
    for (int i = 4; i <= 7; i++) drive(1'b1, 4'(i), 1'b0);
    drive(1'b0, 4'd0, 1'b1);
    checks++; if (err_count !== 8'd0 || sticky_err !== 1'b0 || first_bad !== 4'd0) begin errors++; $display("FAIL clear2 got cnt=%0d st=%b fb=%0d exp 0/0/0", err_count, sticky_err, first_bad); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL clear2_locked got=%b exp=1", locked); end
  endtask

  task automatic test_gaps;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'd2, 1'b0);
      checks++; if (error !== 1'b0 || locked !== 1'b1 || exp_count !== 4'd8) begin errors++; $display("FAIL gap[%0d] got err=%b lock=%b exp=%0d want 0/1/8", i, error, locked, exp_count); end
    end
    drive(1'b1, 4'd8, 1'b0);
    checks++; if (error !== 1'b0 || locked !== 1'b1 || exp_count !== 4'd9) begin errors++; $display("FAIL gap_resume got err=%b lock=%b exp=%0d want 0/1/9", error, locked, exp_count); end
  endtask

  task automatic test_async_reset;
    en = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0; #1;
    checks++; if (locked !== 1'b0 || error !== 1'b0 || sticky_err !== 1'b0 || err_count !== 8'd0 || exp_count !== 4'd0 || first_bad !== 4'd0) begin
      errors++; $display("FAIL async_rst got lock=%b err=%b st=%b cnt=%0d exp=%0d fb=%0d want all 0", locked, error, sticky_err, err_count, exp_count, first_bad);
    end
    #1 rst = 1'b1;
    drive(1'b1, 4'd3, 1'b0);
    checks++; if (exp_count !== 4'd4 || locked !== 1'b0) begin errors++; $display("FAIL post_rst_idle got exp=%0d lock=%b want 4/0", exp_count, locked); end
    for (int i = 4; i <= 6; i++) drive(1'b1, 4'(i), 1'b0);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL post_rst_early got=%b exp=0", locked); end
    drive(1'b1, 4'd7, 1'b0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL post_rst_lock got=%b exp=1", locked); end
    en = 1'b0;
  endtask

  task automatic test_saturate;
    logic [3:0] v, bad;
    drive2(1'b1, 4'd0, 1'b0);
    checks++; if (locked2 !== 1'b0) begin errors++; $display("FAIL l1_idle got=%b exp=0", locked2); end
    drive2(1'b1, 4'd1, 1'b0);
    checks++; if (locked2 !== 1'b1) begin errors++; $display("FAIL l1_lock got=%b exp=1", locked2); end
    v = 4'd1;
    for (int i = 0; i < 5; i++) begin
      bad = v + 4'd3;
      drive2(1'b1, bad, 1'b0);
      checks++; if (error2 !== 1'b1) begin errors++; $display("FAIL sat_err[%0d] got=%b exp=1", i, error2); end
      v = bad + 4'd1;
      drive2(1'b1, v, 1'b0);
    end
    checks++; if (err_count2 !== 2'd3 || sticky_err2 !== 1'b1 || first_bad2 !== 4'd4) begin errors++; $display("FAIL sat got cnt=%0d st=%b fb=%0d want 3/1/4", err_count2, sticky_err2, first_bad2); end
    bad = v + 4'd5;
    drive2(1'b1, bad, 1'b1);
    checks++; if (err_count2 !== 2'd1 || sticky_err2 !== 1'b1 || first_bad2 !== bad || error2 !== 1'b1) begin
      errors++; $display("FAIL clear_vs_err got cnt=%0d st=%b fb=%0d err=%b want 1/1/%0d/1", err_count2, sticky_err2, first_bad2, error2, bad);
    end
    drive2(1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_lock();
    test_wrap();
    test_error();
    test_stall_clear();
    test_gaps();
    test_async_reset();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/count_checker.md
COUNT_CHECKER -- requirements
Module: count_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the width of the observed count bus.
REQ-002 SHALL have parameter LOCK_LEN, default 4, meaning the number of consecutive correct increments required to lock (legal range 1..15).
REQ-003 SHALL have parameter ERR_W, default 8, meaning the width of the error counter.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port en, input, 1 bit: count_in is sampled this cycle.
REQ-007 SHALL have port count_in, input, WIDTH bits: the observed count value from the counter under observation.
REQ-008 SHALL have port clear, input, 1 bit: synchronous clear of the error statistics.
REQ-009 SHALL have port locked, output, 1 bit: the checker is tracking a valid increment sequence.
REQ-010 SHALL have port error, output, 1 bit: one-cycle pulse on a sequence violation while locked.
REQ-011 SHALL have port sticky_err, output, 1 bit: at least one error has occurred since reset or clear.
REQ-012 SHALL have port err_count, output, ERR_W bits: saturating count of errors.
REQ-013 SHALL have port exp_count, output, WIDTH bits: the value expected on the next sample.
REQ-014 SHALL have port first_bad, output, WIDTH bits: the count_in value of the first error since reset or clear.

Function
REQ-015 SHALL implement three states: IDLE, SYNC and LOCK; all outputs SHALL be registered.
REQ-016 Expected value SHALL be prev+1 modulo 2^WIDTH (for example 15 -> 0 when WIDTH=4); exp_count SHALL equal prev+1 whenever the state is not IDLE, and 0 in IDLE.
REQ-017 Cycles with en=0 SHALL leave all state unchanged, except that clear is still honoured and error returns to 0.
REQ-018 IDLE, en=1: prev SHALL take count_in, the run counter SHALL be set to 0, and the state SHALL go to SYNC.
REQ-019 SYNC, en=1, count_in==exp: prev SHALL take count_in and the run counter SHALL increment; when the run counter reaches LOCK_LEN, the state SHALL go to LOCK and locked SHALL be 1 from the next cycle.
REQ-020 SYNC, en=1, mismatch: prev SHALL take count_in and the run counter SHALL be set to 0; no error SHALL be raised and the state SHALL stay in SYNC.
REQ-021 LOCK, en=1, match: prev SHALL take count_in and the state SHALL stay in LOCK.
REQ-022 LOCK, en=1, mismatch (including a repeated value, i.e. a stalled counter): error SHALL be 1 in the next cycle only; err_count SHALL increment, saturating at 2^ERR_W-1; sticky_err SHALL be set to 1; if sticky_err was 0, first_bad SHALL take count_in; prev SHALL take count_in, the run counter SHALL be set to 0, the state SHALL go to SYNC, and locked SHALL be 0 from the next cycle.
REQ-023 Error latency: exactly one clock from the violating sample to the error pulse; locked SHALL fall on the same edge that raises error.
REQ-024 clear=1: err_count, sticky_err and first_bad SHALL be set to 0 on the next edge; the state, prev, the run counter and locked SHALL be unaffected.
REQ-025 clear coincident with an error: the error SHALL win over the clear; the result SHALL be err_count=1, sticky_err=1 and first_bad=the violating count_in.
REQ-026 LOCK_LEN=1: a single correct increment after IDLE or SYNC entry SHALL lock.

Reset
REQ-027 rst=0 SHALL, asynchronously and regardless of clk, force the state to IDLE, prev=0, run=0, locked=0, error=0, sticky_err=0, err_count=0, exp_count=0 and first_bad=0.
REQ-028 Reset asserted mid-sequence SHALL discard lock; after release, relock SHALL require a fresh IDLE -> SYNC -> LOCK pass (LOCK_LEN+1 samples).
REQ-029 Deassertion of rst SHALL take effect so that the first rising edge with rst=1 and en=1 is treated as an IDLE sample.

Verification
REQ-030 Reset release, then en=1 with count 0,1,2,3,4 (defaults) -> locked=1 the cycle after the sample of 4; error never asserted; exp_count=5.
REQ-031 Locked stream 14,15,0,1 -> wrap accepted; error=0 and locked stays 1.
REQ-032 Locked stream 5,6,9 -> error pulses one cycle after the 9; err_count=1; sticky_err=1; first_bad=9; locked=0; the stream 10,11,12,13 then relocks.
REQ-033 Locked stream 7,7 (stall) -> error pulse; a second violation after relock leaves first_bad unchanged and gives err_count=2; then clear=1 -> err_count=0, sticky_err=0, first_bad=0, locked unchanged.
REQ-034 ERR_W=2: force 5 errors -> err_count saturates at 3; clear coincident with a violation -> err_count=1.
REQ-035 rst pulsed low between clock edges while locked -> all outputs 0 immediately, without waiting for a clock edge; en gaps (en=0 for 3 cycles mid-stream) -> no state change and no error.
